// File: rtl/gcd_arbiter.sv
// +------------------------------------------------------------------------+
// | gcd_arbiter: round-robin sharing of one iterative GCD engine among       |
// | NREQ requesters; zero operands are answered without the engine.          |
// | Optional macro GCD_TIMEOUT_EN adds a WAIT-state watchdog (err flag).     |
// | Revision: 1.0 - initial release                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module gcd_arbiter #(
    parameter int NREQ           = 2,
    parameter int WIDTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] x_flat,
    input  logic [NREQ*WIDTH-1:0] y_flat,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      result,
    output logic                  err,
    output logic                  busy,
    output logic [NREQ-1:0]       grant,
    output logic                  eng_start,
    output logic [WIDTH-1:0]      eng_x,
    output logic [WIDTH-1:0]      eng_y,
    input  logic                  eng_done,
    input  logic [WIDTH-1:0]      eng_result
);

    localparam int            c_PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0]    c_IDLE  = 2'd0;
    localparam logic [1:0]    c_ISSUE = 2'd1;
    localparam logic [1:0]    c_WAIT  = 2'd2;
    localparam logic [1:0]    c_RESP  = 2'd3;
    localparam logic [NREQ-1:0] c_ONE = NREQ'(1);

    logic [1:0]       r_state, w_state_nxt;
    logic [c_PW-1:0]  r_ptr, w_ptr_nxt;
    logic [c_PW-1:0]  r_gidx, w_gidx_nxt;
    logic [NREQ-1:0]  r_grant, w_grant_nxt;
    logic [NREQ-1:0]  r_ack, w_ack_nxt;
    logic             r_start, w_start_nxt;
    logic [WIDTH-1:0] r_eng_x, w_eng_x_nxt;
    logic [WIDTH-1:0] r_eng_y, w_eng_y_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_busy;
    logic             w_found;
    logic [c_PW-1:0]  w_sel;
    logic             w_tmo_hit;

    // First requester after the last-served index wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            automatic int idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_sel   = c_PW'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_gidx_nxt   = r_gidx;
        w_grant_nxt  = r_grant;
        w_ack_nxt    = '0;
        w_start_nxt  = 1'b0;
        w_eng_x_nxt  = r_eng_x;
        w_eng_y_nxt  = r_eng_y;
        w_result_nxt = r_result;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_gidx_nxt  = w_sel;
                    w_grant_nxt = c_ONE << w_sel;
                    w_eng_x_nxt = x_flat[w_sel*WIDTH +: WIDTH];
                    w_eng_y_nxt = y_flat[w_sel*WIDTH +: WIDTH];
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                // The subtractive engine never finishes on a zero operand.
                if (r_eng_x == '0 || r_eng_y == '0) begin
                    w_result_nxt = r_eng_x | r_eng_y;
                    w_state_nxt  = c_RESP;
                end else begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = c_WAIT;
                end
            end
            c_WAIT: begin
                if (eng_done) begin
                    w_result_nxt = eng_result;
                    w_state_nxt  = c_RESP;
                end else if (w_tmo_hit) begin
                    w_result_nxt = '0;
                    w_state_nxt  = c_RESP;
                end
            end
            c_RESP: begin
                w_ack_nxt   = r_grant;
                w_ptr_nxt   = r_gidx;
                w_grant_nxt = '0;
                w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state  <= c_IDLE;
            r_ptr    <= c_PW'(NREQ - 1);
            r_gidx   <= '0;
            r_grant  <= '0;
            r_ack    <= '0;
            r_start  <= 1'b0;
            r_eng_x  <= '0;
            r_eng_y  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gidx   <= w_gidx_nxt;
            r_grant  <= w_grant_nxt;
            r_ack    <= w_ack_nxt;
            r_start  <= w_start_nxt;
            r_eng_x  <= w_eng_x_nxt;
            r_eng_y  <= w_eng_y_nxt;
            r_result <= w_result_nxt;
            r_busy   <= (w_state_nxt != c_IDLE);
        end
    end

`ifdef GCD_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TW-1:0] r_tcnt;
    logic            r_err;

    assign w_tmo_hit = (r_state == c_WAIT) && (r_tcnt == c_TW'(TIMEOUT_CYCLES - 1));

    // err stays up through RESP and the following ack cycle.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == c_ISSUE)
                r_tcnt <= '0;
            else if (r_state == c_WAIT)
                r_tcnt <= r_tcnt + 1'b1;
            if (r_state == c_WAIT && !eng_done && w_tmo_hit)
                r_err <= 1'b1;
            else if (r_state == c_IDLE)
                r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign w_tmo_hit = 1'b0;
    assign err       = 1'b0;
`endif

    assign ack       = r_ack;
    assign result    = r_result;
    assign busy      = r_busy;
    assign grant     = r_grant;
    assign eng_start = r_start;
    assign eng_x     = r_eng_x;
    assign eng_y     = r_eng_y;

endmodule

`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_gcd_arbiter: directed vectors plus a behavioural GCD engine peer.     |
// | Revision: 1.0 - initial release                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_gcd_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic [1:0] req;
    logic [7:0] x_flat, y_flat;
    logic [1:0] ack, grant;
    logic [3:0] result, eng_x, eng_y, eng_result;
    logic       err, busy, eng_start, eng_done;

    always #5 clk = ~clk;

    gcd_arbiter #(.NREQ(2), .WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .clr(clr), .req(req), .x_flat(x_flat), .y_flat(y_flat),
        .ack(ack), .result(result), .err(err), .busy(busy), .grant(grant),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_result(eng_result)
    );

    // Engine peer: done pulses eng_delay cycles after it sees start.
    int         eng_delay = 1;
    bit         eng_hang  = 1'b0;
    logic       inj_done  = 1'b0;
    logic       m_done    = 1'b0;
    logic [3:0] m_res     = '0;
    logic [3:0] m_a, m_b;
    bit         m_busy    = 1'b0;
    int         m_cnt     = 0;

    function automatic logic [3:0] gcd4(input logic [3:0] a_in, input logic [3:0] b_in);
        int a = a_in, b = b_in, t;
        while (b != 0) begin
            t = a % b; a = b; b = t;
        end
        return 4'(a);
    endfunction

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (eng_start && !eng_hang) begin
            m_busy <= 1'b1;
            m_cnt  <= eng_delay;
            m_a    <= eng_x;
            m_b    <= eng_y;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_done <= 1'b1;
                m_res  <= gcd4(m_a, m_b);
                m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign eng_done   = m_done | inj_done;
    assign eng_result = m_res;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Results of the last transaction.
    logic [1:0] got_ack;
    logic [3:0] got_res, got_sx, got_sy;
    logic       got_err, got_busy, got_to;
    int         got_lat, got_starts;

    task automatic run_txn(input logic [1:0] rq, input logic [7:0] xf,
                           input logic [7:0] yf, input int dly);
        bit fin = 1'b0;
        @(negedge clk);
        eng_delay = dly;
        req = rq; x_flat = xf; y_flat = yf;
        got_lat = 0; got_starts = 0; got_to = 1'b0;
        got_sx = '0; got_sy = '0;
        while (!fin && got_lat < 200) begin
            @(posedge clk);
            got_lat++;
            @(negedge clk);
            if (eng_start) begin
                got_starts++;
                got_sx = eng_x; got_sy = eng_y;
            end
            if (ack != 2'b00) begin
                got_ack = ack; got_res = result; got_err = err; got_busy = busy;
                req = 2'b00;
                fin = 1'b1;
            end
        end
        if (!fin) begin
            got_to = 1'b1;
            check("ack_wait_timeout", 1, 0);
        end
    endtask

    typedef struct {
        logic [1:0] rq;
        logic [3:0] x0, y0, x1, y1;
        int         dly;
        logic [1:0] eack;
        logic [3:0] eres;
        int         estart;
        int         elat;
    } vec_t;

    vec_t tv[8];

    initial begin
        tv[0] = '{2'b01, 4'd12, 4'd8,  4'd0,  4'd0,  5, 2'b01, 4'd4,  1, 10};
        tv[1] = '{2'b10, 4'd0,  4'd0,  4'd0,  4'd9,  1, 2'b10, 4'd9,  0, 3};
        tv[2] = '{2'b10, 4'd0,  4'd0,  4'd0,  4'd0,  1, 2'b10, 4'd0,  0, 3};
        tv[3] = '{2'b01, 4'd7,  4'd0,  4'd0,  4'd0,  1, 2'b01, 4'd7,  0, 3};
        tv[4] = '{2'b01, 4'd15, 4'd10, 4'd0,  4'd0,  2, 2'b01, 4'd5,  1, 7};
        tv[5] = '{2'b10, 4'd0,  4'd0,  4'd9,  4'd6,  3, 2'b10, 4'd3,  1, 8};
        tv[6] = '{2'b10, 4'd0,  4'd0,  4'd15, 4'd15, 1, 2'b10, 4'd15, 1, 6};
        tv[7] = '{2'b01, 4'd1,  4'd14, 4'd0,  4'd0,  4, 2'b01, 4'd1,  1, 9};

        // Reset held with both requesters active.
        clr = 1'b0; req = 2'b11;
        x_flat = {4'd9, 4'd15}; y_flat = {4'd6, 4'd10};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_start", eng_start, 0);
        check("rst_engxy", {eng_x, eng_y}, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);

        // Round-robin with req held high: first grant goes to requester 0.
        eng_delay = 2;
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rr_first_grant", grant, 1);
        check("rr_busy", busy, 1);
        for (int t = 0; t < 4; t++) begin
            int cyc = 0;
            while (ack == 2'b00 && cyc < 100) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
            check("rr_ack", ack, (t % 2 == 0) ? 1 : 2);
            check("rr_result", result, (t % 2 == 0) ? 5 : 3);
            if (t == 3) req = 2'b00;
            @(posedge clk);
            @(negedge clk);
        end
        check("rr_idle_busy", busy, 0);
        check("rr_result_hold", result, 3);

        // Request dropped and operands changed right after the grant edge.
        @(negedge clk);
        eng_delay = 3;
        req = 2'b01; x_flat = {4'd0, 4'd12}; y_flat = {4'd0, 4'd8};
        @(posedge clk);
        @(negedge clk);
        req = 2'b00; x_flat = 8'hFF; y_flat = 8'h33;
        begin
            int cyc = 0;
            while (ack == 2'b00 && cyc < 100) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        check("drop_ack", ack, 1);
        check("drop_result", result, 4);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_txn(tv[i].rq, {tv[i].x1, tv[i].x0}, {tv[i].y1, tv[i].y0}, tv[i].dly);
            if (!got_to) begin
                check($sformatf("v%0d_ack", i), got_ack, tv[i].eack);
                check($sformatf("v%0d_result", i), got_res, tv[i].eres);
                check($sformatf("v%0d_err", i), got_err, 0);
                check($sformatf("v%0d_busy", i), got_busy, 0);
                check($sformatf("v%0d_latency", i), got_lat, tv[i].elat);
                check($sformatf("v%0d_starts", i), got_starts, tv[i].estart);
                if (tv[i].estart > 0) begin
                    check($sformatf("v%0d_engx", i), got_sx,
                          (tv[i].eack == 2'b01) ? tv[i].x0 : tv[i].x1);
                    check($sformatf("v%0d_engy", i), got_sy,
                          (tv[i].eack == 2'b01) ? tv[i].y0 : tv[i].y1);
                end
            end
        end

        // Reset during WAIT, then a stale done.
        eng_hang = 1'b1;
        @(negedge clk);
        req = 2'b01; x_flat = {4'd0, 4'd12}; y_flat = {4'd0, 4'd8};
        begin
            int cyc = 0;
            while (!eng_start && cyc < 20) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
            check("midwait_start_seen", eng_start, 1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        req = 2'b00; clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1; inj_done = 1'b1;
        check("midwait_rst_result", result, 0);
        check("midwait_rst_engx", eng_x, 0);
        @(posedge clk);
        @(negedge clk);
        inj_done = 1'b0;
        begin
            bit seen = 1'b0, bz = 1'b0;
            for (int c = 0; c < 5; c++) begin
                if (ack != 2'b00) seen = 1'b1;
                if (busy || grant != 2'b00) bz = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end
            check("stale_done_ack", seen, 0);
            check("stale_done_busy", bz, 0);
        end
        eng_hang = 1'b0;
        run_txn(2'b01, {4'd0, 4'd9}, {4'd0, 4'd6}, 2);
        check("post_rst_ack", got_ack, 1);
        check("post_rst_result", got_res, 3);
        check("post_rst_latency", got_lat, 7);

`ifdef GCD_TIMEOUT_EN
        // Watchdog: 16 WAIT cycles without done.
        eng_hang = 1'b1;
        run_txn(2'b01, {4'd0, 4'd5}, {4'd0, 4'd3}, 1);
        check("tmo_ack", got_ack, 1);
        check("tmo_result", got_res, 0);
        check("tmo_err", got_err, 1);
        check("tmo_latency", got_lat, 19);
        @(negedge clk);
        check("tmo_err_clear", err, 0);
        eng_hang = 1'b0;
        // done in the 16th WAIT cycle wins over the limit.
        run_txn(2'b01, {4'd0, 4'd5}, {4'd0, 4'd3}, 14);
        check("tmo_edge_result", got_res, 1);
        check("tmo_edge_err", got_err, 0);
        check("tmo_edge_latency", got_lat, 19);
        // done one cycle too late: timeout.
        run_txn(2'b01, {4'd0, 4'd5}, {4'd0, 4'd3}, 15);
        check("tmo_late_result", got_res, 0);
        check("tmo_late_err", got_err, 1);
        repeat (4) @(posedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
